// File: rtl/ddr_tx_word_serializer.sv
// ddr_tx_word_serializer
// Takes whole HDR-DDR words (CMD, DATA or CRC) from the DDR/CCC engine and
// shifts them out MSB first, one bit per SCL edge strobe. Preamble, parity,
// CRC token and the running CRC-5 are generated here. A one-entry buffer lets
// the next word be queued while the current one is on the wire, so
// consecutive words stream with no idle strobes between them.
//
// Ports:
//   i_sys_clk, i_sys_rst            clock, synchronous active-high reset
//   i_sclgen_scl_pos_edge/neg_edge  SCL edge strobes (either one advances a bit)
//   i_ddrccc_word_valid/mode/data   word offer (mode 00 CMD, 01 DATA, 10 CRC, 11 illegal)
//   o_ddrccc_word_ready             buffer slot free
//   o_ddrccc_word_done              one-cycle pulse when a word has fully left
//   o_ddrccc_busy                   a word is being shifted
//   o_ddrccc_err                    one-cycle pulse when an illegal word is dropped
//   o_sdahnd_serial_data            registered SDA bit
//   o_crc_value                     running CRC register
module ddr_tx_word_serializer #(
    parameter int                DATA_W   = 16,
    parameter int                CRC_W    = 5,
    parameter logic [CRC_W-1:0]  CRC_POLY = 5'h05,
    parameter logic [CRC_W-1:0]  CRC_INIT = 5'h1F
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_sclgen_scl_pos_edge,
    input  logic              i_sclgen_scl_neg_edge,
    input  logic              i_ddrccc_word_valid,
    input  logic [1:0]        i_ddrccc_word_mode,
    input  logic [DATA_W-1:0] i_ddrccc_word_data,
    output logic              o_ddrccc_word_ready,
    output logic              o_ddrccc_word_done,
    output logic              o_ddrccc_busy,
    output logic              o_ddrccc_err,
    output logic              o_sdahnd_serial_data,
    output logic [CRC_W-1:0]  o_crc_value
);

    localparam int WORD_LEN = DATA_W + 4;
    localparam int CRC_LEN  = CRC_W + 6;
    localparam int LMAX     = (WORD_LEN > CRC_LEN) ? WORD_LEN : CRC_LEN;
    localparam int LEN_W    = $clog2(LMAX + 1);

    localparam logic [1:0] MODE_CMD  = 2'b00;
    localparam logic [1:0] MODE_DATA = 2'b01;
    localparam logic [1:0] MODE_CRC  = 2'b10;
    localparam logic [1:0] MODE_BAD  = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]        state_reg;
    logic              buf_full_reg;
    logic [1:0]        buf_mode_reg;
    logic [DATA_W-1:0] buf_data_reg;
    logic [LMAX-1:0]   shift_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  cnt_reg;
    logic [1:0]        mode_reg;
    logic              sda_reg;
    logic              done_reg;
    logic              err_reg;
    logic              ready_reg;
    logic [CRC_W-1:0]  crc_reg;

    logic              strobe;
    logic              accept;
    logic              buf_legal;
    logic              at_end;
    logic              payload_bit;
    logic              shift_bit;
    logic              crc_fb;
    logic [CRC_W-1:0]  crc_next;
    logic [CRC_W-1:0]  crc_src;
    logic              load_now;
    logic              drop_now;
    logic              buf_full_next;
    logic [LMAX-1:0]   load_bits;
    logic [LEN_W-1:0]  load_len;
    logic [DATA_W/2-1:0] odd_bits;
    logic [DATA_W/2-1:0] even_bits;
    logic              pa1;
    logic              pa0;
    logic [1:0]        preamble;

    // Split the buffered payload into odd and even bit lanes for parity.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W / 2; gi++) begin : g_parity_lanes
            assign odd_bits[gi]  = buf_data_reg[2*gi + 1];
            assign even_bits[gi] = buf_data_reg[2*gi];
        end
    endgenerate

    assign pa1      = ^odd_bits;
    assign pa0      = ~(^even_bits);
    assign preamble = (buf_mode_reg == MODE_DATA) ? 2'b10 : 2'b01;

    assign strobe    = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
    assign accept    = i_ddrccc_word_valid & ready_reg;
    assign buf_legal = buf_full_reg && (buf_mode_reg != MODE_BAD);
    assign at_end    = (cnt_reg == len_reg);
    assign shift_bit = shift_reg[LMAX-1];

    // Only DATA payload bits (positions 2 .. DATA_W+1) feed the CRC.
    assign payload_bit = (mode_reg == MODE_DATA) &&
                         (cnt_reg >= LEN_W'(2)) &&
                         (cnt_reg <= LEN_W'(DATA_W + 1));

    assign crc_fb   = crc_reg[CRC_W-1] ^ shift_bit;
    assign crc_next = {crc_reg[CRC_W-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);

    // A CRC word finishing in this same strobe reseeds the CRC, so a CRC word
    // loaded back-to-back behind it must see the fresh seed.
    assign crc_src = ((state_reg == ST_SHIFT) && (mode_reg == MODE_CRC)) ? CRC_INIT : crc_reg;

    // Buffered word, left-aligned so the first bit to send sits at the MSB.
    always_comb begin
        load_bits = '0;
        load_len  = LEN_W'(WORD_LEN);
        if (buf_mode_reg == MODE_CRC) begin
            load_bits[LMAX-1 -: CRC_LEN] = {2'b01, 4'b1100, crc_src};
            load_len                     = LEN_W'(CRC_LEN);
        end else begin
            load_bits[LMAX-1 -: WORD_LEN] = {preamble, buf_data_reg, pa1, pa0};
        end
    end

    assign load_now = buf_legal &&
                      ((state_reg == ST_IDLE) ||
                       ((state_reg == ST_SHIFT) && strobe && at_end));
    assign drop_now = (state_reg == ST_IDLE) && buf_full_reg && !buf_legal;

    always_comb begin
        buf_full_next = buf_full_reg;
        if (load_now || drop_now) begin
            buf_full_next = 1'b0;
        end
        if (accept) begin
            buf_full_next = 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_reg    <= ST_IDLE;
            buf_full_reg <= 1'b0;
            buf_mode_reg <= MODE_CMD;
            buf_data_reg <= '0;
            shift_reg    <= '0;
            len_reg      <= '0;
            cnt_reg      <= '0;
            mode_reg     <= MODE_CMD;
            sda_reg      <= 1'b1;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            ready_reg    <= 1'b0;
            crc_reg      <= CRC_INIT;
        end else begin
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            buf_full_reg <= buf_full_next;
            ready_reg    <= ~buf_full_next;
            if (accept) begin
                buf_mode_reg <= i_ddrccc_word_mode;
                buf_data_reg <= i_ddrccc_word_data;
            end

            case (state_reg)
                ST_IDLE: begin
                    sda_reg <= 1'b1;
                    if (drop_now) begin
                        err_reg <= 1'b1;
                    end else if (load_now) begin
                        shift_reg <= load_bits;
                        len_reg   <= load_len;
                        cnt_reg   <= '0;
                        mode_reg  <= buf_mode_reg;
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (strobe) begin
                        if (!at_end) begin
                            sda_reg   <= shift_bit;
                            shift_reg <= {shift_reg[LMAX-2:0], 1'b0};
                            cnt_reg   <= cnt_reg + LEN_W'(1);
                            if (payload_bit) begin
                                crc_reg <= crc_next;
                            end
                        end else begin
                            // Last bit has been held for one half-period.
                            done_reg <= 1'b1;
                            if (mode_reg == MODE_CRC) begin
                                crc_reg <= CRC_INIT;
                            end
                            if (load_now) begin
                                // Back-to-back: first bit of the next word goes out now.
                                sda_reg   <= load_bits[LMAX-1];
                                shift_reg <= {load_bits[LMAX-2:0], 1'b0};
                                len_reg   <= load_len;
                                cnt_reg   <= LEN_W'(1);
                                mode_reg  <= buf_mode_reg;
                            end else begin
                                sda_reg   <= 1'b1;
                                state_reg <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_ddrccc_word_ready  = ready_reg;
    assign o_ddrccc_word_done   = done_reg;
    assign o_ddrccc_busy        = (state_reg == ST_SHIFT);
    assign o_ddrccc_err         = err_reg;
    assign o_sdahnd_serial_data = sda_reg;
    assign o_crc_value          = crc_reg;

endmodule

// File: tb/tb_ddr_tx_word_serializer.sv
// Bench for ddr_tx_word_serializer: a word-level model (bit lists built from
// the word formats, a pending-word slot, a position into the active word)
// checked against the DUT every cycle, plus directed literal checks.
module tb_ddr_tx_word_serializer;

    logic        clk;
    logic        rst;
    logic        scl_pos;
    logic        scl_neg;
    logic        word_valid;
    logic [1:0]  word_mode;
    logic [15:0] word_data;
    logic        word_ready;
    logic        word_done;
    logic        busy;
    logic        err;
    logic        sda;
    logic [4:0]  crc_value;

    int n_checks = 0;
    int n_bad    = 0;
    logic coinc  = 1'b0;

    ddr_tx_word_serializer dut (
        .i_sys_clk             (clk),
        .i_sys_rst             (rst),
        .i_sclgen_scl_pos_edge (scl_pos),
        .i_sclgen_scl_neg_edge (scl_neg),
        .i_ddrccc_word_valid   (word_valid),
        .i_ddrccc_word_mode    (word_mode),
        .i_ddrccc_word_data    (word_data),
        .o_ddrccc_word_ready   (word_ready),
        .o_ddrccc_word_done    (word_done),
        .o_ddrccc_busy         (busy),
        .o_ddrccc_err          (err),
        .o_sdahnd_serial_data  (sda),
        .o_crc_value           (crc_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- strobe generator: one strobe every 4 clocks ----------
    initial begin
        int  sc;
        logic alt;
        sc = 0;
        alt = 1'b0;
        scl_pos = 1'b0;
        scl_neg = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            scl_pos = 1'b0;
            scl_neg = 1'b0;
            sc++;
            if (sc % 4 == 0) begin
                if (coinc) begin
                    scl_pos = 1'b1;
                    scl_neg = 1'b1;
                end else if (alt) begin
                    scl_pos = 1'b1;
                end else begin
                    scl_neg = 1'b1;
                end
                alt = ~alt;
            end
        end
    end

    // ---------------- word-level model --------------------------------------
    // Word bits left-aligned in 32 bits, first bit to send at [31].
    function automatic logic [31:0] build_bits(input logic [1:0] md, input logic [15:0] d,
                                                input logic [4:0] c);
        logic [31:0] w;
        logic p1;
        logic p0;
        w = '0;
        if (md == 2'b10) begin
            w[31:21] = {2'b01, 4'b1100, c};
        end else begin
            p1 = 1'b0;
            p0 = 1'b1;
            for (int i = 0; i < 16; i++) begin
                if (i % 2 == 1) p1 = p1 ^ d[i];
                else            p0 = p0 ^ d[i];
            end
            w[31:12] = {(md == 2'b01) ? 2'b10 : 2'b01, d, p1, p0};
        end
        return w;
    endfunction

    function automatic int word_len(input logic [1:0] md);
        return (md == 2'b10) ? 11 : 20;
    endfunction

    logic        m_sda = 1'b1;
    logic        m_ready = 1'b0;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic        m_busy = 1'b0;
    logic [4:0]  m_crc = 5'h1F;
    logic        m_has_buf = 1'b0;
    logic [1:0]  m_buf_mode = 2'b00;
    logic [15:0] m_buf_data = 16'h0;
    logic [31:0] m_bits = '0;
    int          m_len = 0;
    int          m_pos = 0;
    logic [1:0]  m_act_mode = 2'b00;

    task automatic start_word();
        m_bits     = build_bits(m_buf_mode, m_buf_data, m_crc);
        m_len      = word_len(m_buf_mode);
        m_act_mode = m_buf_mode;
        m_has_buf  = 1'b0;
    endtask

    task automatic model_step();
        logic acc;
        logic b;
        logic fb;
        if (rst) begin
            m_sda     = 1'b1;
            m_ready   = 1'b0;
            m_done    = 1'b0;
            m_err     = 1'b0;
            m_busy    = 1'b0;
            m_crc     = 5'h1F;
            m_has_buf = 1'b0;
            m_pos     = 0;
        end else begin
            acc    = word_valid && m_ready;
            m_done = 1'b0;
            m_err  = 1'b0;
            if (!m_busy) begin
                if (m_has_buf) begin
                    if (m_buf_mode == 2'b11) begin
                        m_err     = 1'b1;
                        m_has_buf = 1'b0;
                    end else begin
                        start_word();
                        m_pos  = 0;
                        m_busy = 1'b1;
                    end
                end
            end else if (scl_pos || scl_neg) begin
                if (m_pos < m_len) begin
                    b = m_bits[31 - m_pos];
                    if (m_act_mode == 2'b01 && m_pos >= 2 && m_pos <= 17) begin
                        fb    = m_crc[4] ^ b;
                        m_crc = {m_crc[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
                    end
                    m_sda = b;
                    m_pos++;
                end else begin
                    m_done = 1'b1;
                    if (m_act_mode == 2'b10) m_crc = 5'h1F;
                    if (m_has_buf && m_buf_mode != 2'b11) begin
                        start_word();
                        m_sda = m_bits[31];
                        m_pos = 1;
                    end else begin
                        m_sda  = 1'b1;
                        m_busy = 1'b0;
                    end
                end
            end
            if (acc) begin
                m_has_buf  = 1'b1;
                m_buf_mode = word_mode;
                m_buf_data = word_data;
            end
            m_ready = !m_has_buf;
        end
    endtask

    // ---------------- per-cycle compare process -----------------------------
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("sda",   32'(sda),        32'(m_sda));
            chk("ready", 32'(word_ready), 32'(m_ready));
            chk("done",  32'(word_done),  32'(m_done));
            chk("busy",  32'(busy),       32'(m_busy));
            chk("err",   32'(err),        32'(m_err));
            chk("crc",   32'(crc_value),  32'(m_crc));
            if (m_done) $display("word done: mode=%0d len=%0d crc=%h t=%0t", m_act_mode, m_len, m_crc, $time);
            if (m_err)  $display("word dropped: illegal mode t=%0t", $time);
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic send_word(input logic [1:0] md, input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        word_valid = 1'b1;
        word_mode  = md;
        word_data  = d;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (word_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        word_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (word_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 32'(0), 32'(1));
    endtask

    // Counts strobes seen while busy up to the done pulse (first bit .. done).
    task automatic count_strobes(output int n);
        bit ok;
        ok = 1'b0;
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (word_done) begin
                ok = 1'b1;
                break;
            end
            if (busy && (scl_pos || scl_neg)) n++;
        end
        if (!ok) chk("strobe_count_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        logic [31:0] pw;
        int n;
        rst        = 1'b1;
        word_valid = 1'b0;
        word_mode  = 2'b00;
        word_data  = 16'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sda",   32'(sda),        32'(1));
        chk("rst_ready", 32'(word_ready), 32'(0));
        chk("rst_crc",   32'(crc_value),  32'h1F);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_rst", 32'(word_ready), 32'(1));

        // Pin the model's word builder to hand-computed words
        pw = build_bits(2'b00, 16'h0000, 5'h00);
        chk("pin_cmd0000",  32'(pw[31:12]), 32'(20'b01_0000_0000_0000_0000_01));
        pw = build_bits(2'b01, 16'hA5A5, 5'h00);
        chk("pin_dataA5A5", 32'(pw[31:12]), 32'(20'b10_1010_0101_1010_0101_01));
        pw = build_bits(2'b01, 16'h0001, 5'h00);
        chk("pin_data0001", 32'(pw[31:12]), 32'(20'b10_0000_0000_0000_0001_00));
        pw = build_bits(2'b10, 16'h0000, 5'h01);
        chk("pin_crcword",  32'(pw[31:21]), 32'(11'b01_1100_00001));

        // CMD 0000: 21 strobes from first bit to done, then idle
        send_word(2'b00, 16'h0000);
        count_strobes(n);
        chk("cmd_strobes", 32'(n), 32'(21));
        chk("cmd_idle_busy", 32'(busy), 32'(0));
        chk("cmd_idle_sda",  32'(sda),  32'(1));

        // Two DATA words streamed
        send_word(2'b01, 16'hA5A5);
        send_word(2'b01, 16'h0001);
        wait_done();
        wait_done();

        // Reset mid-word with a word also waiting in the buffer
        send_word(2'b01, 16'h1234);
        send_word(2'b00, 16'hBEEF);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midrst_sda",   32'(sda),        32'(1));
        chk("midrst_ready", 32'(word_ready), 32'(0));
        chk("midrst_busy",  32'(busy),       32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ready_after", 32'(word_ready), 32'(1));
        chk("midrst_crc",         32'(crc_value),  32'h1F);
        repeat (20) @(posedge clk);

        // DATA 0000 followed by CRC word, streamed
        send_word(2'b01, 16'h0000);
        send_word(2'b10, 16'h0000);
        wait_done();
        chk("crc_after_data", 32'(crc_value), 32'h01);
        wait_done();
        chk("crc_reseeded", 32'(crc_value), 32'h1F);

        // Illegal mode: one err pulse, buffer frees
        send_word(2'b11, 16'h5555);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (err) n++;
        end
        chk("err_pulses",      32'(n),          32'(1));
        chk("ready_after_err", 32'(word_ready), 32'(1));
        chk("err_no_sda",      32'(sda),        32'(1));

        // Coincident pos/neg strobes advance one bit each
        coinc = 1'b1;
        send_word(2'b00, 16'hFFFF);
        count_strobes(n);
        chk("coinc_strobes", 32'(n), 32'(21));
        coinc = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr_tx_word_serializer.md
# ddr_tx_word_serializer

Parametrised HDR-DDR word transmitter between the DDR/CCC engine and the SDA handler. It accepts whole words (command, data or CRC) over a valid/ready handshake and buffers one word ahead for gap-free streaming. It generates preamble, parity, CRC token and CRC-5 internally, runs its own bit counter, and emits one bit per SCL edge strobe.

## Interface
- DATA_W, 16: payload bits in CMD/DATA words; even, ≥ 8.
- CRC_W, 5: CRC width.
- CRC_POLY, 5'h05: CRC polynomial, implicit top term.
- CRC_INIT, 5'h1F: CRC seed.
- i_sys_clk  in  1  system clock; all logic on rising edge.
- i_sys_rst  in  1  synchronous, active-high reset.
- i_sclgen_scl_pos_edge  in  1  one-cycle strobe, SCL rising.
- i_sclgen_scl_neg_edge  in  1  one-cycle strobe, SCL falling.
- i_ddrccc_word_valid  in  1  word offered.
- i_ddrccc_word_mode  in  2  00 CMD, 01 DATA, 10 CRC, 11 illegal.
- i_ddrccc_word_data  in  DATA_W  payload (ignored for CRC).
- o_ddrccc_word_ready  out  1  buffer slot free.
- o_ddrccc_word_done  out  1  one-cycle pulse, word fully emitted.
- o_ddrccc_busy  out  1  shifting in progress.
- o_ddrccc_err  out  1  one-cycle pulse, illegal mode accepted.
- o_sdahnd_serial_data  out  1  registered SDA bit.
- o_crc_value  out  CRC_W  running CRC register.

## Operation
- Strobe = pos_edge | neg_edge; both high in one cycle counts as one strobe.
- One-entry buffer holds {mode, data}. Accept when valid & ready. Ready = buffer empty.
- Word formats, MSB first:
  - CMD: preamble 01, DATA_W payload, PA1, PA0. Length DATA_W+4.
  - DATA: preamble 10, DATA_W payload, PA1, PA0. Length DATA_W+4.
  - CRC: preamble 01, token 1100, CRC_W CRC bits. Length 6+CRC_W.
- Parity is computed on the payload:
  - PA1 = XOR of payload odd bits (1,3,…,DATA_W-1).
  - PA0 = XOR of payload even bits (0,2,…) XOR 1.
- CRC covers DATA payload bits only, updated as each bit is driven:
  - fb = crc[CRC_W-1] ^ bit.
  - crc = (crc << 1) ^ (fb ? CRC_POLY : 0).
  - CRC word sends the current crc.
  - crc reloads to CRC_INIT in the cycle the CRC word's done pulse fires.
- Mode 11: word accepted from buffer, never shifted. o_ddrccc_err pulses when it is dropped. Buffer frees.
- States:
  - IDLE: SDA=1, busy=0. If buffer full and legal, load shift register and length, clear bit counter, free buffer, go to SHIFT.
  - SHIFT: on each strobe with cnt < len, drive bit[cnt] and increment cnt.
  - On a strobe with cnt == len (last bit held one half-period): pulse done.
    - If the buffer holds a legal word, load it and drive its first bit on the same strobe, with cnt = 1 (back-to-back).
    - Otherwise SDA <= 1 and go to IDLE.
- Strobes in IDLE are ignored.

## Timing
- Reset values: o_sdahnd_serial_data=1, o_ddrccc_word_ready=0, o_ddrccc_word_done=0, o_ddrccc_busy=0, o_ddrccc_err=0, o_crc_value=CRC_INIT. State=IDLE, buffer empty.
- Ready rises in the first cycle after reset deasserts.
- Reset mid-word aborts immediately: SDA=1 next cycle, buffer discarded, CRC reseeded.
- Accept at cycle t:
  - Buffer full at t+1.
  - If IDLE, SHIFT and ready=1 at t+2.
  - First bit appears on the clock after the first strobe at or after t+2.
- Accept and load in the same cycle: buffer may be refilled in the cycle it is freed (ready stays 1).
- SDA and done are registered and change in the cycle after the causing strobe.
- Word occupies len+1 strobes from first bit to done; streaming words add zero idle strobes.

## Test plan
- Reset held 3 cycles mid-word -> SDA=1, ready=0 during reset, ready=1 one cycle after release, crc=5'h1F.
- CMD 16'h0000, strobes every 4 clocks -> SDA 01, 16×0, 0,1 (PA=01), done after 21st strobe, then SDA=1, busy=0.
- DATA 16'hA5A5 -> 10,1010010110100101,01. DATA 16'h0001 -> parity 00.
- DATA 16'h0000 then CRC offered before first word ends -> no gap. CRC word 01,1100,00001. crc reads 5'h1F after done.
- Mode 11 offered -> err pulses once, no SDA activity, ready returns 1.
- Pos and neg strobes coincident for one cycle -> exactly one bit advance.
